// File: rtl/mem_requester.sv
// mem_requester: 2-deep request FIFO feeding a single-outstanding 256-bit memory bus initiator.
// Define MEM_FIXED_LATENCY_EN to complete after MEM_LAT wait cycles instead of memFleg/timeout.
module mem_requester #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_rw,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              memEN,
    output logic              memRW,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] toMemBus,
    input  logic [DATA_W-1:0] memBus,
    input  logic              memFleg
);

    localparam int CNT_MAX = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] qAddr [2];
    logic [DATA_W-1:0] qData [2];
    logic [1:0]        qRw;
    logic              wrPtr;
    logic              rdPtr;
    logic [1:0]        count;
    logic [1:0]        countNext;
    logic [CNT_W-1:0]  waitCnt;
    logic              push;
    logic              pop;

    assign push = req_valid && req_ready;
    assign pop  = (state == IDLE) && (count != 2'd0);

    always_comb begin
        countNext = count;
        if (push && !pop) begin
            countNext = count + 2'd1;
        end else if (pop && !push) begin
            countNext = count - 2'd1;
        end
    end

    // req_ready is registered from the next occupancy so it never depends on req_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            req_ready <= 1'b1;
            qRw       <= '0;
            for (int i = 0; i < 2; i++) begin
                qAddr[i] <= '0;
                qData[i] <= '0;
            end
        end else begin
            count     <= countNext;
            req_ready <= (countNext != 2'd2);
            if (push) begin
                qAddr[wrPtr] <= req_addr;
                qData[wrPtr] <= req_wdata;
                qRw[wrPtr]   <= req_rw;
                wrPtr        <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waitCnt    <= '0;
            memEN      <= 1'b0;
            memRW      <= 1'b0;
            memAddr    <= '0;
            toMemBus   <= '0;
            resp_valid <= 1'b0;
            resp_rw    <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        memEN    <= 1'b1;
                        memRW    <= qRw[rdPtr];
                        memAddr  <= qAddr[rdPtr];
                        toMemBus <= qRw[rdPtr] ? '0 : qData[rdPtr];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    memEN   <= 1'b0;
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
`ifdef MEM_FIXED_LATENCY_EN
                    if (waitCnt == CNT_W'(MEM_LAT - 1)) begin
                        resp_rdata <= memRW ? memBus : '0;
                        resp_err   <= 1'b0;
                        resp_rw    <= memRW;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`else
                    // completion is checked first so it beats the terminal count
                    if (memFleg) begin
                        resp_rdata <= memRW ? memBus : '0;
                        resp_err   <= 1'b0;
                        resp_rw    <= memRW;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_rw    <= memRW;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed scenarios plus a randomized run against a
// queue-based transaction model and a behavioural memory responder.
module tb_mem_requester;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_rw;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          memEN;
    logic          memRW;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] toMemBus;
    logic [DW-1:0] memBus;
    logic          memFleg;

    mem_requester #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .MEM_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rw(resp_rw), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memEN(memEN), .memRW(memRW), .memAddr(memAddr),
        .toMemBus(toMemBus), .memBus(memBus), .memFleg(memFleg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    logic [DW-1:0] refMem [256];
    logic [DW-1:0] tbMem  [256];
    int            delayQ [$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] A5;

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: flag arrives in WAIT cycle d+1; timeout fires in WAIT cycle TO.
    function automatic exp_t model(input logic rw, input logic [AW-1:0] a,
                                   input logic [DW-1:0] wd, input int d);
        exp_t e;
        e.rw    = rw;
        e.addr  = a;
        e.wdata = rw ? '0 : wd;
        if (!rw) refMem[a] = wd;
        e.err   = (d >= TO);
        e.rdata = (e.err || !rw) ? '0 : refMem[a];
        e.lat   = e.err ? TO + 1 : d + 2;
        delayQ.push_back(d);
        return e;
    endfunction

    // Memory: each issue takes the next delay; 255 means never answer.
    int            cd;
    logic          pend = 1'b0;
    logic          pendRw;
    logic [AW-1:0] pendAddr;
    always @(negedge clk) begin
        memFleg = 1'b0;
        memBus  = rand256();
        if (!rst_n) begin
            pend = 1'b0;
        end else if (memEN === 1'b1) begin
            if (!memRW) tbMem[memAddr] = toMemBus;
            if (delayQ.size() > 0) cd = delayQ.pop_front();
            else cd = 0;
            pend     = (cd != 255);
            pendRw   = memRW;
            pendAddr = memAddr;
        end else if (pend) begin
            if (cd == 0) begin
                memFleg = 1'b1;
                pend    = 1'b0;
                if (pendRw) memBus = tbMem[pendAddr];
            end else begin
                cd--;
            end
        end
    end

    task automatic do_req(input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int d, output bit ok);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (ok) begin
            req_valid = 1'b1;
            req_rw    = rw;
            req_addr  = a;
            req_wdata = wd;
            void'(model(rw, a, wd, d));
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_memen(output int c);
        c = 0;
        while (memEN !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (memEN !== 1'b1) c = -1;
    endtask

    task automatic wait_resp(output int c);
        c = 0;
        while (resp_valid !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (resp_valid !== 1'b1) c = -1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({memEN, memRW, resp_valid, resp_rw, resp_err} !== 5'b0 || memAddr !== '0) begin
            errors++;
            $display("FAIL reset_ctl: en=%b rw=%b rv=%b rrw=%b err=%b addr=%h, want all 0",
                     memEN, memRW, resp_valid, resp_rw, resp_err, memAddr);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        checks++;
        if (toMemBus !== '0 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: toMemBus=%h rdata=%h want 0", toMemBus, resp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || memEN !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b en=%b rv=%b want 1/0/0",
                     req_ready, memEN, resp_valid);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        int c;
        resp_ready = 1'b1;
        do_req(1'b0, 8'h05, A5, 0, ok);
        wait_memen(c);
        checks++;
        if (!ok || c != 1 || memRW !== 1'b0 || memAddr !== 8'h05 || toMemBus !== A5) begin
            errors++;
            $display("FAIL wr_issue: ok=%0d lat=%0d rw=%b addr=%h data=%h want lat 1 rw 0 addr 05 data %h",
                     ok, c, memRW, memAddr, toMemBus, A5);
        end
        @(negedge clk);
        checks++;
        if (memEN !== 1'b0 || memAddr !== 8'h05) begin
            errors++;
            $display("FAIL wr_pulse: en=%b addr=%h want 0 and 05", memEN, memAddr);
        end
        wait_resp(c);
        checks++;
        if (c != 1 || resp_rw !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: lat=%0d rw=%b rdata=%h err=%b want 1/0/0/0",
                     c, resp_rw, resp_rdata, resp_err);
        end
        @(negedge clk);
        do_req(1'b1, 8'h05, rand256(), 0, ok);
        wait_memen(c);
        checks++;
        if (!ok || c != 1 || memRW !== 1'b1 || memAddr !== 8'h05 || toMemBus !== '0) begin
            errors++;
            $display("FAIL rd_issue: ok=%0d lat=%0d rw=%b addr=%h data=%h want lat 1 rw 1 addr 05 data 0",
                     ok, c, memRW, memAddr, toMemBus);
        end
        @(negedge clk);
        checks++;
        if (memEN !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse: en=%b want 0", memEN);
        end
        wait_resp(c);
        checks++;
        if (c != 1 || resp_rw !== 1'b1 || resp_rdata !== A5 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: lat=%0d rw=%b rdata=%h err=%b want 1/1/%h/0",
                     c, resp_rw, resp_rdata, resp_err, A5);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [3];
        logic [AW-1:0] seen [$];
        int nResp = 0;
        exp_t e;
        a[0] = 8'h40;
        a[1] = 8'h41;
        a[2] = 8'h42;
        resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (memEN === 1'b1) seen.push_back(memAddr);
            if (resp_valid === 1'b1) nResp++;
            if (c == 3) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full: ready=%b want 0", req_ready);
                end
            end
            if (c < 3) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: ready=%b want 1", c, req_ready);
                end
                req_valid = 1'b1;
                req_rw    = 1'b0;
                req_addr  = a[c];
                req_wdata = rand256();
                e = model(1'b0, a[c], req_wdata, 0);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (seen.size() != 3 || nResp != 3 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: issues=%0d resps=%0d ready=%b want 3/3/1",
                     seen.size(), nResp, req_ready);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== a[i]) begin
                    errors++;
                    $display("FAIL b2b_order%0d: addr=%h want %h", i, seen[i], a[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        int c;
        logic [DW-1:0] wd;
        wd = rand256();
        resp_ready = 1'b1;
        do_req(1'b1, 8'h10, '0, 255, ok1);
        do_req(1'b0, 8'h11, wd, 0, ok2);
        wait_memen(c);
        checks++;
        if (!ok1 || !ok2 || c < 0 || memAddr !== 8'h10 || memRW !== 1'b1) begin
            errors++;
            $display("FAIL to_issue: ok=%0d%0d c=%0d addr=%h rw=%b want addr 10 rw 1",
                     ok1, ok2, c, memAddr, memRW);
        end
        wait_resp(c);
        checks++;
        if (c != TO + 1 || resp_err !== 1'b1 || resp_rdata !== '0 || resp_rw !== 1'b1) begin
            errors++;
            $display("FAIL to_resp: lat=%0d err=%b rdata=%h rw=%b want %0d/1/0/1",
                     c, resp_err, resp_rdata, resp_rw, TO + 1);
        end
        @(negedge clk);
        wait_memen(c);
        checks++;
        if (c < 0 || memAddr !== 8'h11 || memRW !== 1'b0 || toMemBus !== wd) begin
            errors++;
            $display("FAIL to_next_issue: c=%0d addr=%h rw=%b data=%h want addr 11 rw 0 data %h",
                     c, memAddr, memRW, toMemBus, wd);
        end
        wait_resp(c);
        checks++;
        if (c != 2 || resp_err !== 1'b0 || resp_rw !== 1'b0 || resp_rdata !== '0) begin
            errors++;
            $display("FAIL to_next_resp: lat=%0d err=%b rw=%b rdata=%h want 2/0/0/0",
                     c, resp_err, resp_rw, resp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok1, ok2, ok3;
        bit bad = 0;
        int c;
        resp_ready = 1'b0;
        do_req(1'b1, 8'h05, '0, 0, ok1);
        do_req(1'b0, 8'h20, rand256(), 0, ok2);
        do_req(1'b0, 8'h21, rand256(), 0, ok3);
        wait_resp(c);
        checks++;
        if (!ok1 || !ok2 || !ok3 || c < 0) begin
            errors++;
            $display("FAIL bp_setup: ok=%0d%0d%0d c=%0d want all accepted and a response",
                     ok1, ok2, ok3, c);
        end
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_rw !== 1'b1 || resp_rdata !== A5 ||
                resp_err !== 1'b0 || memEN !== 1'b0 || req_ready !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: rv=%b rw=%b err=%b en=%b ready=%b rdata=%h want 1/1/0/0/0 %h",
                     resp_valid, resp_rw, resp_err, memEN, req_ready, resp_rdata, A5);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            wait_resp(c);
            checks++;
            if (c < 0 || resp_rw !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
                errors++;
                $display("FAIL bp_drain%0d: c=%0d rw=%b err=%b rdata=%h want write ok",
                         k, c, resp_rw, resp_err, resp_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random(input int n);
        exp_t issQ [$];
        exp_t rspQ [$];
        exp_t e;
        int sent = 0, got = 0, cyc = 0, issueCyc = 0, r, d;
        bit latDone = 1;
        logic rw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        while (got < n && cyc < 20000) begin
            if (memEN === 1'b1) begin
                issueCyc = cyc;
                latDone  = 0;
                checks++;
                if (issQ.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_issue: unexpected memEN addr=%h", memAddr);
                end else begin
                    e = issQ.pop_front();
                    if (memRW !== e.rw || memAddr !== e.addr || toMemBus !== e.wdata) begin
                        errors++;
                        $display("FAIL rnd_issue: rw=%b addr=%h data=%h want %b %h %h",
                                 memRW, memAddr, toMemBus, e.rw, e.addr, e.wdata);
                    end
                end
            end
            if (resp_valid === 1'b1 && !latDone) begin
                latDone = 1;
                checks++;
                if (rspQ.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_lat: response with nothing outstanding");
                end else if (cyc - issueCyc != rspQ[0].lat) begin
                    errors++;
                    $display("FAIL rnd_lat: got %0d want %0d", cyc - issueCyc, rspQ[0].lat);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            if (resp_valid === 1'b1 && resp_ready) begin
                checks++;
                got++;
                if (rspQ.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_resp: unexpected response");
                end else begin
                    e = rspQ.pop_front();
                    if (resp_rw !== e.rw || resp_rdata !== e.rdata || resp_err !== e.err) begin
                        errors++;
                        $display("FAIL rnd_resp: rw=%b err=%b rdata=%h want %b %b %h",
                                 resp_rw, resp_err, resp_rdata, e.rw, e.err, e.rdata);
                    end
                end
            end
            if (sent < n && $urandom_range(0, 9) < 6) begin
                rw = 1'($urandom_range(0, 1));
                a  = 8'($urandom_range(0, 15));
                wd = rand256();
                r  = $urandom_range(0, 19);
                if (r < 14) d = r % 4;
                else if (r == 14) d = TO - 1;
                else if (r == 15) d = TO;
                else if (r < 18) d = 255;
                else d = TO - 2;
                req_valid = 1'b1;
                req_rw    = rw;
                req_addr  = a;
                req_wdata = wd;
                if (req_ready === 1'b1) begin
                    e = model(rw, a, wd, d);
                    issQ.push_back(e);
                    rspQ.push_back(e);
                    sent++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        checks++;
        if (got != n || rspQ.size() != 0 || issQ.size() != 0) begin
            errors++;
            $display("FAIL rnd_done: got %0d of %0d, %0d/%0d left after %0d cycles",
                     got, n, issQ.size(), rspQ.size(), cyc);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok1, ok2;
        bit bad = 0;
        int c;
        resp_ready = 1'b1;
        do_req(1'b1, 8'h33, '0, 255, ok1);
        do_req(1'b0, 8'h34, rand256(), 0, ok2);
        wait_memen(c);
        checks++;
        if (!ok1 || !ok2 || c < 0 || memAddr !== 8'h33) begin
            errors++;
            $display("FAIL rst_setup: ok=%0d%0d c=%0d addr=%h want addr 33", ok1, ok2, c, memAddr);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (memEN !== 1'b0 || resp_valid !== 1'b0 || memAddr !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: en=%b rv=%b addr=%h ready=%b want 0/0/00/1",
                     memEN, resp_valid, memAddr, req_ready);
        end
        delayQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || memEN !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_discard: rv=%b en=%b want no activity after reset", resp_valid, memEN);
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        A5         = {32{8'hA5}};
        for (int i = 0; i < 256; i++) begin
            refMem[i] = '0;
            tbMem[i]  = '0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_random(80);
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
